// File: rtl/s2p_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s2p_deserializer_pkg
// Description : Shared constants and FSM state encoding for the 4-lane
//               serial-to-parallel deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package s2p_deserializer_pkg;

    // Default lane count (Q0..Q3 are fixed to four lanes in this revision)
    localparam int DEF_LANES = 4;

    // Default bits per lane per word
    localparam int DEF_WIDTH = 8;

    // Alignment byte, recognised on lane 0 only
    localparam logic [7:0] SYNC_BYTE = 8'hBC;

    // Alignment FSM states
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage : s2p_deserializer_pkg
`default_nettype wire

// File: rtl/s2p_lane.sv
`default_nettype none
// ============================================================================
// Module      : s2p_lane
// Description : One serial lane: MSB-first shift register plus a capture
//               register loaded on the word boundary. The sync-detecting
//               lane also reports whether the byte completing this cycle
//               equals the alignment byte.
// Revision    : 1.0 - initial release
// ============================================================================
module s2p_lane #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC        = 8'hBC,
    parameter bit               SYNC_DETECT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_bit,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_q,
    output logic             o_match
);

    // Only WIDTH-1 history bits are kept: the oldest bit of a full byte is
    // never observed because the byte is always taken together with the
    // bit arriving in the current cycle.
    logic [WIDTH-2:0] sh_q, sh_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] w_nxt;

    // Byte including the bit presented this cycle
    assign w_nxt = {sh_q, i_bit};

    // Shift on enable; capture the completed byte when the top asks for it
    always_comb begin
        sh_d = sh_q;
        q_d  = q_q;
        if (i_en) begin
            sh_d = w_nxt[WIDTH-2:0];
            if (i_load) begin
                q_d = w_nxt;
            end
        end
    end

    // Lane state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
            q_q  <= '0;
        end else begin
            sh_q <= sh_d;
            q_q  <= q_d;
        end
    end

    assign o_q     = q_q;
    assign o_match = SYNC_DETECT && (w_nxt == SYNC);

endmodule : s2p_lane
`default_nettype wire

// File: rtl/s2p_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : s2p_deserializer
// Description : Receiver for the 4-lane p2s serializer. Aligns to byte
//               boundaries with two consecutive SYNC bytes on lane 0, then
//               rebuilds one byte per lane per word and strobes valid for
//               one cycle. SYNC bytes seen while locked are fillers.
// Revision    : 1.0 - initial release
// ============================================================================
module s2p_deserializer
    import s2p_deserializer_pkg::*;
#(
    parameter int               LANES = DEF_LANES,
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC  = SYNC_BYTE
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     ENB,
    input  logic [LANES-1:0]         data_in,
    output logic [WIDTH-1:0]         Q0,
    output logic [WIDTH-1:0]         Q1,
    output logic [WIDTH-1:0]         Q2,
    output logic [WIDTH-1:0]         Q3,
    output logic                     valid,
    output logic                     locked,
    output logic [$clog2(WIDTH)-1:0] sel
);

    localparam int               SEL_W    = $clog2(WIDTH);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             w_load;
    logic             w_sync_hit;
    logic [LANES-1:0] w_match;
    logic [WIDTH-1:0] w_q [LANES];

    // One shift/capture lane per serial input; lane 0 detects SYNC
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        s2p_lane #(
            .WIDTH       (WIDTH),
            .SYNC        (SYNC),
            .SYNC_DETECT (i == 0)
        ) u_lane (
            .clk     (CLK),
            .rst_n   (reset),
            .i_en    (ENB),
            .i_bit   (data_in[i]),
            .i_load  (w_load),
            .o_q     (w_q[i]),
            .o_match (w_match[i])
        );
    end

    // Only lane 0 ever reports a match, so the OR is the lane-0 comparison
    assign w_sync_hit = |w_match;

    // Alignment FSM, bit counter and capture strobe; everything freezes while ENB=0
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        w_load  = 1'b0;
        if (ENB) begin
            case (state_q)
                ST_SEARCH: begin
                    sel_d = '0;
                    if (w_sync_hit) begin
                        state_d = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (sel_q == SEL_LAST) begin
                        sel_d   = '0;
                        state_d = w_sync_hit ? ST_LOCKED : ST_SEARCH;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (sel_q == SEL_LAST) begin
                        sel_d = '0;
                        // A SYNC byte on the boundary is a filler, not data
                        if (!w_sync_hit) begin
                            w_load  = 1'b1;
                            valid_d = 1'b1;
                        end
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    sel_d   = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Control registers; reset drops lock and discards any partial byte
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_SEARCH;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign Q0     = w_q[0];
    assign Q1     = w_q[1];
    assign Q2     = w_q[2];
    assign Q3     = w_q[3];
    assign valid  = valid_q;
    assign locked = locked_q;
    assign sel    = sel_q;

endmodule : s2p_deserializer
`default_nettype wire
